button_conditioner: RTL

Front-end input stage for the calculator: takes the five raw board push-buttons (btnc, btnl, btnu, btnr, btnd), synchronises them to clk, debounces each independently, and emits a clean level plus a single-cycle press pulse per button. The calculator core consumes the conditioned levels for ALU operation selection and the press pulses for accumulator load and clear. Without this stage, one physical press of btnd would apply the operation once per clock.

---
 rtl/button_conditioner.sv | 85 ++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Front-end stage for the five board push-buttons. Each button is brought into
// the clk domain through a two-flop synchroniser and then debounced: the
// conditioned level only follows the synchronised input once the input has
// disagreed with the current level for DEBOUNCE_CYCLES consecutive cycles.
// A one-cycle press strobe accompanies every debounced 0->1 change.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive disagreeing cycles needed to change the level
//                    (legal 2 .. 2^24)
//   CNT_W            counter width, 2^CNT_W >= DEBOUNCE_CYCLES
//
// Ports
//   clk        system clock, all state changes on its rising edge
//   rst_n      asynchronous active-low reset, clears every register
//   btn_in     raw buttons, asynchronous to clk
//              bit0 btnc, bit1 btnl, bit2 btnu, bit3 btnr, bit4 btnd
//   btn_level  debounced level per button, same bit order
//   btn_press  one-cycle strobe per button on each debounced rising change
//
// Interface semantics: there is no valid/ready handshake. btn_level is a
// registered level valid every cycle; btn_press is a registered strobe that is
// high for exactly one cycle, coincident with the cycle btn_level first reads 1.
// Consumers need no backpressure; a strobe missed is simply lost.
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] btn_in,
  output logic [4:0] btn_level,
  output logic [4:0] btn_press
);

  localparam int                NUM_BTN  = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] sync2;
  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] press;
  logic [CNT_W-1:0]   cnt [NUM_BTN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      level <= '0;
      press <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (sync2[i] == level[i]) begin
          // Input agrees with the level: any partial count from a glitch is
          // discarded so separate glitches never add up.
          cnt[i]   <= '0;
          press[i] <= 1'b0;
        end else if (cnt[i] == CNT_LAST) begin
          // Disagreement has lasted the full threshold: adopt the new level.
          // The strobe carries the new value, so only a rise produces one.
          level[i] <= sync2[i];
          cnt[i]   <= '0;
          press[i] <= sync2[i];
        end else begin
          // cnt stops at CNT_LAST, so it can never wrap.
          cnt[i]   <= cnt[i] + CNT_ONE;
          press[i] <= 1'b0;
        end
      end
    end
  end

  assign btn_level = level;
  assign btn_press = press;

endmodule
